// File: rtl/pipeline_front_ctrl.sv
// Front-end pipeline controller: PC / IF-ID / ID-EX enables for branches,
// load-use hazards and instruction-memory waits, with a fetch-timeout halt.
module pipeline_front_ctrl #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic        load_use,
    input  logic        branch_taken,
    output logic        pc_enable,
    output logic        if_id_enable,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        fetch_timeout,
    output logic [15:0] stall_cycles,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        DISCARD = 2'b01,
        HALT    = 2'b10
    } fsm_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    fsm_t        state_q;
    logic [7:0]  wait_cnt;
    logic [3:0]  ctrl;
    logic        active;
    logic        timeout_hit;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Encoding 11 is not in the active set, so it behaves exactly like HALT.
    assign active      = (state_q == RUN) || (state_q == DISCARD);
    assign timeout_hit = active && !imem_ready && (wait_cnt == WAIT_LAST);

    // ctrl = {pc_enable, if_id_enable, if_id_flush, id_ex_bubble}
    always_comb begin
        ctrl = 4'b0011;
        if (reset) begin
            case (state_q)
                RUN: begin
                    if (branch_taken)     ctrl = 4'b1011;
                    else if (load_use)    ctrl = 4'b0001;
                    else if (!imem_ready) ctrl = 4'b0010;
                    else                  ctrl = 4'b1100;
                end
                DISCARD: begin
                    ctrl = branch_taken ? 4'b1011 : 4'b0010;
                end
                default: ctrl = 4'b0011;
            endcase
        end
    end

    assign pc_enable    = ctrl[3];
    assign if_id_enable = ctrl[2];
    assign if_id_flush  = ctrl[1];
    assign id_ex_bubble = ctrl[0];
    assign state        = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            wait_cnt      <= 8'd0;
            fetch_timeout <= 1'b0;
            stall_cycles  <= 16'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (timeout_hit)                      state_q <= HALT;
                    else if (branch_taken && !imem_ready) state_q <= DISCARD;
                    else                                  state_q <= RUN;
                end
                DISCARD: begin
                    // A new branch restarts the fetch, so the in-flight one is still junk.
                    if (timeout_hit)       state_q <= HALT;
                    else if (branch_taken) state_q <= DISCARD;
                    else if (imem_ready)   state_q <= RUN;
                    else                   state_q <= DISCARD;
                end
                default: state_q <= HALT;
            endcase

            if (active) begin
                wait_cnt <= imem_ready ? 8'd0 : sat_inc8(wait_cnt);
                if (!pc_enable)
                    stall_cycles <= sat_inc16(stall_cycles);
            end

            if (timeout_hit)
                fetch_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_front_ctrl.sv
// Self-checking bench for pipeline_front_ctrl: directed hazard scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_pipeline_front_ctrl;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_ready = 1'b0;
    logic        load_use = 1'b0;
    logic        branch_taken = 1'b0;
    logic        pc_enable, if_id_enable, if_id_flush, id_ex_bubble;
    logic        fetch_timeout;
    logic [15:0] stall_cycles;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;

    // Model: mode 0=run, 1=discard, 2=halt; m_low = consecutive not-ready cycles.
    int m_mode = 0;
    int m_low = 0;
    int m_stall = 0;
    int m_tmo = 0;

    pipeline_front_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .imem_ready(imem_ready), .load_use(load_use),
        .branch_taken(branch_taken), .pc_enable(pc_enable), .if_id_enable(if_id_enable),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .fetch_timeout(fetch_timeout), .stall_cycles(stall_cycles), .state(state)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {pc_enable, if_id_enable, if_id_flush, id_ex_bubble}
    function automatic logic [3:0] exp_out(input int mode, input bit ir, input bit lu, input bit br);
        if (mode == 2) return 4'b0011;
        if (mode == 1) return br ? 4'b1011 : 4'b0010;
        if (br)  return 4'b1011;
        if (lu)  return 4'b0001;
        if (!ir) return 4'b0010;
        return 4'b1100;
    endfunction

    function automatic logic [31:0] exp_stall();
        return (m_stall > 65535) ? 32'd65535 : 32'(m_stall);
    endfunction

    function automatic logic [31:0] outs();
        return {28'd0, pc_enable, if_id_enable, if_id_flush, id_ex_bubble};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_low = 0; m_stall = 0; m_tmo = 0;
    endtask

    // Drive inputs, check the cycle's outputs, then advance the model over the next edge.
    task automatic check_and_advance(input bit ir, input bit lu, input bit br);
        logic [3:0] e;
        imem_ready = ir; load_use = lu; branch_taken = br;
        #1;
        e = exp_out(m_mode, ir, lu, br);
        chk("outs",  outs(), {28'd0, e});
        chk("state", {30'd0, state}, 32'(m_mode));
        chk("stall", {16'd0, stall_cycles}, exp_stall());
        chk("tmo",   {31'd0, fetch_timeout}, 32'(m_tmo));
        if (m_mode != 2) begin
            if (!e[3]) m_stall++;
            if (ir) m_low = 0; else m_low++;
            if (!ir && m_low == MAX_WAIT) begin
                m_mode = 2; m_tmo = 1;
            end else if (m_mode == 0) begin
                if (br && !ir) m_mode = 1;
            end else begin
                if (br) m_mode = 1;
                else if (ir) m_mode = 0;
            end
        end
    endtask

    task automatic step(input bit ir, input bit lu, input bit br);
        @(negedge clk);
        check_and_advance(ir, lu, br);
    endtask

    // Reset pulse entirely between two rising edges; inputs stay as they were.
    task automatic pulse_reset();
        @(negedge clk);
        chk("pre_rst_state", {30'd0, state}, 32'(m_mode));
        #1 reset = 1'b0;
        #1;
        chk("rst_outs",  outs(), 32'b0011);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_stall", {16'd0, stall_cycles}, 32'd0);
        chk("rst_tmo",   {31'd0, fetch_timeout}, 32'd0);
        #1 reset = 1'b1;
        #1;
        model_reset();
        chk("post_rst_state", {30'd0, state}, 32'd0);
        chk("post_rst_stall", {16'd0, stall_cycles}, 32'd0);
        check_and_advance(imem_ready, load_use, branch_taken);
    endtask

    initial begin
        // Power-on reset held across several edges: nothing counts.
        repeat (3) @(negedge clk);
        #1;
        chk("por_outs",  outs(), 32'b0011);
        chk("por_state", {30'd0, state}, 32'd0);
        chk("por_stall", {16'd0, stall_cycles}, 32'd0);
        chk("por_tmo",   {31'd0, fetch_timeout}, 32'd0);
        #1 reset = 1'b1;
        model_reset();

        // Load-use hazard as the very first cycle: stall count 0 -> 1.
        check_and_advance(1, 1, 0);
        step(1, 0, 0);
        chk("lu_stall_one", {16'd0, stall_cycles}, 32'd1);
        step(1, 0, 0);

        // Branch with fetch in flight, then memory returns two cycles later.
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("br_back_run", {30'd0, state}, 32'd0);

        // Branch, load-use and wait all at once: branch wins.
        step(0, 1, 1);
        step(1, 0, 0);
        step(1, 0, 0);

        // Async reset pulse while discarding.
        step(0, 0, 1);
        pulse_reset();
        step(1, 0, 0);

        // Timeout after MAX_WAIT low cycles; HALT ignores ready until reset.
        repeat (MAX_WAIT) step(0, 0, 0);
        repeat (3) step(1, 1, 1);
        chk("halt_state", {30'd0, state}, 32'd2);
        chk("halt_tmo",   {31'd0, fetch_timeout}, 32'd1);
        pulse_reset();

        // Saturation of the stall counter.
        repeat (70000) step(1, 1, 0);
        step(1, 0, 0);
        chk("stall_sat", {16'd0, stall_cycles}, 32'hFFFF);
        pulse_reset();

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2)
                pulse_reset();
            else
                step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2);
        end
        step(1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
